// File: rtl/gemm_tile_checker.sv
`timescale 1ns/1ps
// gemm_tile_checker: streams result rows and golden rows in lockstep, compares
// signed lanes (exactly or within an absolute tolerance), counts mismatching
// lanes and records the first mismatch location and values.
module gemm_tile_checker #(
    parameter int COLS   = 4,
    parameter int ELEM_W = 32,
    parameter int DATA_W = 256,
    parameter int ROW_W  = 16,
    parameter int TOL_W  = 8,
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROW_W-1:0]  num_rows,
    input  logic              mode,
    input  logic [TOL_W-1:0]  tolerance,
    input  logic              act_valid,
    output logic              act_ready,
    input  logic [DATA_W-1:0] act_data,
    input  logic              exp_valid,
    output logic              exp_ready,
    input  logic [DATA_W-1:0] exp_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ROW_W+7:0]  err_count,
    output logic [ROW_W-1:0]  first_row,
    output logic [COL_W-1:0]  first_col,
    output logic [ELEM_W-1:0] first_act,
    output logic [ELEM_W-1:0] first_exp
);

    localparam int LANE_BITS = COLS * ELEM_W;
    localparam int CNT_W     = $clog2(COLS + 1);
    localparam int MAG_W     = (ELEM_W + 1 > TOL_W) ? ELEM_W + 1 : TOL_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ROW_W-1:0]     rows_total;
    logic [ROW_W-1:0]     row_cnt;
    logic                 mode_r;
    logic [TOL_W-1:0]     tol_r;
    logic                 cmp_valid;
    logic [LANE_BITS-1:0] cmp_act;
    logic [LANE_BITS-1:0] cmp_exp;
    logic [ROW_W-1:0]     cmp_row;
    logic                 found;

    logic                 consume;
    logic                 accept;
    logic [COLS-1:0]      lane_mis;
    logic [CNT_W-1:0]     mis_cnt;
    logic [COL_W-1:0]     hit_col;
    logic [ELEM_W-1:0]    hit_act;
    logic [ELEM_W-1:0]    hit_exp;
    logic [ROW_W+8:0]     err_sum;
    logic [ROW_W+7:0]     err_next;

    // Bits above the lane payload carry nothing for this block.
    generate
        if (DATA_W > LANE_BITS) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^{act_data[DATA_W-1:LANE_BITS], exp_data[DATA_W-1:LANE_BITS]};
        end
    endgenerate

    assign consume = (state_q == S_RUN) && act_valid && exp_valid;
    assign accept  = (state_q == S_IDLE) && start;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and handshake/status outputs.
    always_comb begin
        state_d   = state_q;
        act_ready = 1'b0;
        exp_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = (num_rows == '0) ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                busy      = 1'b1;
                act_ready = exp_valid;
                exp_ready = act_valid;
                if (consume && (row_cnt == rows_total - ROW_W'(1))) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Per-lane compare of the registered row pair, popcount and lowest mismatch lane.
    always_comb begin
        logic signed [ELEM_W:0] diff;
        logic [ELEM_W:0]        abs_d;
        logic [MAG_W-1:0]       mag;
        logic                   hit;
        lane_mis = '0;
        mis_cnt  = '0;
        hit_col  = '0;
        hit_act  = '0;
        hit_exp  = '0;
        hit      = 1'b0;
        diff     = '0;
        abs_d    = '0;
        mag      = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            diff  = $signed({cmp_act[i*ELEM_W+ELEM_W-1], cmp_act[i*ELEM_W +: ELEM_W]})
                  - $signed({cmp_exp[i*ELEM_W+ELEM_W-1], cmp_exp[i*ELEM_W +: ELEM_W]});
            abs_d = diff[ELEM_W] ? $unsigned(-diff) : $unsigned(diff);
            mag   = MAG_W'(abs_d);
            lane_mis[i] = mode_r ? (mag > MAG_W'(tol_r)) : (diff != '0);
            mis_cnt = mis_cnt + CNT_W'(lane_mis[i]);
            if (lane_mis[i] && !hit) begin
                hit     = 1'b1;
                hit_col = COL_W'(i);
                hit_act = cmp_act[i*ELEM_W +: ELEM_W];
                hit_exp = cmp_exp[i*ELEM_W +: ELEM_W];
            end
        end
        err_sum  = {1'b0, err_count} + (ROW_W+9)'(mis_cnt);
        err_next = err_count;
        if (cmp_valid) err_next = err_sum[ROW_W+8] ? '1 : err_sum[ROW_W+7:0];
    end

    // Command latch, row capture into the compare stage, and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rows_total <= '0;
            row_cnt    <= '0;
            mode_r     <= 1'b0;
            tol_r      <= '0;
            cmp_valid  <= 1'b0;
            cmp_act    <= '0;
            cmp_exp    <= '0;
            cmp_row    <= '0;
            found      <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_row  <= '0;
            first_col  <= '0;
            first_act  <= '0;
            first_exp  <= '0;
        end else begin
            cmp_valid <= consume;
            if (consume) begin
                cmp_act <= act_data[LANE_BITS-1:0];
                cmp_exp <= exp_data[LANE_BITS-1:0];
                cmp_row <= row_cnt;
                row_cnt <= row_cnt + ROW_W'(1);
            end
            if (accept) begin
                rows_total <= num_rows;
                mode_r     <= mode;
                tol_r      <= tolerance;
                row_cnt    <= '0;
                found      <= 1'b0;
                pass       <= 1'b0;
                err_count  <= '0;
                first_row  <= '0;
                first_col  <= '0;
                first_act  <= '0;
                first_exp  <= '0;
            end else if (cmp_valid) begin
                err_count <= err_next;
                if ((lane_mis != '0) && !found) begin
                    found     <= 1'b1;
                    first_row <= cmp_row;
                    first_col <= hit_col;
                    first_act <= hit_act;
                    first_exp <= hit_exp;
                end
            end
            // The last row retires during DRAIN, so err_next is final here.
            if (state_q == S_DRAIN) pass <= (err_next == '0);
        end
    end

endmodule
